controle_gpio: RTL and testbench
================================

// Module: controle_gpio
// PURPOSE
//  Input front-end for the ship: samples raw active-low buttons on GPIO_1[4:0].
//  Synchronises and debounces them, then drives the ship movement levels and a fire pulse.
//  Sits directly upstream of nave; the top level wires GPIO_1[4:0] in and move_*/fire_pulse out.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  cycles a new level must hold before it is accepted (10 ms @ 50 MHz)
//  REPEAT_DELAY     25000000 cycles fire held before first auto-repeat (FIRE_AUTOREPEAT_EN only)
//  REPEAT_PERIOD    5000000  cycles between auto-repeat pulses (FIRE_AUTOREPEAT_EN only)
// PORTS
//  CLOCK_50    in   1  system clock, 50 MHz, sole clock domain
//  reset       in   1  synchronous, active-high reset
//  gpio_n      in   5  raw buttons, active-low: [0]left [1]right [2]up [3]down [4]fire
//  btn_state   out  5  debounced levels, active-high, same bit order as gpio_n
//  move_left   out  1  level: move ship left
//  move_right  out  1  level: move ship right
//  move_up     out  1  level: move ship up
//  move_down   out  1  level: move ship down
//  fire_pulse  out  1  one-cycle strobe per accepted fire press
// BEHAVIOUR
//  - Reset: all outputs 0. Sync flops load 1 (released), stable levels 0, counters 0.
//    Behaviour is identical when reset is asserted mid-debounce or mid-repeat.
//  - Per bit: 2-flop synchroniser, then inversion to active-high signal s.
//  - Debounce per bit, with counter cnt and accepted level stable:
//    s == stable -> cnt <= 0.
//    s != stable and cnt == DEBOUNCE_CYCLES-1 -> stable <= s, cnt <= 0.
//    otherwise -> cnt <= cnt+1.
//    A glitch shorter than DEBOUNCE_CYCLES restarts the count and never changes stable.
//  - Counter width $clog2(DEBOUNCE_CYCLES). The counter never wraps: it is cleared at its terminal count.
//  - Latency: a raw edge held steady appears on btn_state 2+DEBOUNCE_CYCLES cycles later.
//    move_* are registered and follow btn_state one cycle later.
//  - Conflict rules: left&right both stable -> move_left=move_right=0. Same for up&down.
//    Horizontal and vertical axes are independent, so diagonal movement is allowed.
//  - fire_pulse is registered. It is high exactly one cycle, the cycle after stable[4] goes 0->1.
//    Release produces no pulse.
// CONFIGURATION
//  Macro FIRE_AUTOREPEAT_EN.
//  - Defined: fire FSM with states IDLE, HOLD, REPEAT.
//    IDLE: on stable[4] rise, emit the pulse, clear the timer, go to HOLD.
//    HOLD: when the timer reaches REPEAT_DELAY-1, emit a pulse, clear the timer, go to REPEAT.
//    REPEAT: emit a pulse every REPEAT_PERIOD cycles.
//    stable[4] falling in any state -> IDLE, no pulse that cycle.
//  - Undefined: no FSM or timer is built; only the press edge pulse exists.
// STRUCTURE
//  - Shared package controle_pkg holds localparams BTN_LEFT=0, BTN_RIGHT=1, BTN_UP=2,
//    BTN_DOWN=3, BTN_FIRE=4, NUM_BTN=5, and the fire FSM state encoding.
//  - Sub-module debounce_bit (parameter DEBOUNCE_CYCLES).
//    Ports: CLOCK_50, reset, raw_n, stable.
//    Contains synchroniser, inversion and counter; instantiated NUM_BTN times via generate.
//  - The top of the block adds conflict logic, edge detect and the optional repeat FSM.
// TESTING  (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1. Reset held 3 cycles, gpio_n=5'b11111 -> all outputs 0.
//     Release reset -> outputs remain 0.
//  2. gpio_n[0]=0 held -> btn_state[0]=1 exactly 6 cycles after the edge, move_left=1 one cycle later.
//     Release -> both return to 0 with the same latency.
//  3. gpio_n[1] low for 3 cycles, then high (bounce) -> btn_state[1] never rises.
//     Counter is back at 0.
//  4. Left and right both held -> btn_state=5'b00011, move_left=move_right=0.
//     Release right -> move_left=1.
//  5. gpio_n[4] held 40 cycles.
//     Without macro -> exactly one fire_pulse.
//     With FIRE_AUTOREPEAT_EN -> pulses at press, +10 and then every 3 cycles until release.
//  6. Assert reset while gpio_n[4] is low mid-debounce and mid-repeat.
//     -> outputs 0 next cycle; after release, a full debounce is required before a new pulse.

Source files
------------

// File: rtl/controle_pkg.sv
// controle_pkg: button indices and fire FSM encoding shared by the GPIO input front-end.
package controle_pkg;
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;
    localparam int BTN_FIRE  = 4;
    localparam int NUM_BTN   = 5;
    typedef enum logic [1:0] {FIRE_IDLE, FIRE_HOLD, FIRE_REPEAT} fire_state_e;
endpackage

// File: rtl/controle_gpio_debounce_bit.sv
// debounce_bit: 2-flop synchroniser, inversion and terminal-count debouncer for one active-low button.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic raw_n,
    output logic stable
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d, s, term;
    assign s    = ~sync_q[1];
    assign term = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    always_comb begin
        cnt_d    = (s == stable_q || term) ? '0 : cnt_q + 1'b1;
        stable_d = (s != stable_q && term) ? s : stable_q;
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_n};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end
    assign stable = stable_q;
endmodule

// File: rtl/controle_gpio.sv
// controle_gpio: debounced ship movement levels and fire pulse from raw active-low GPIO buttons.
// Define FIRE_AUTOREPEAT_EN to build the fire auto-repeat FSM.
module controle_gpio
    import controle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] gpio_n,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               move_left,
    output logic               move_right,
    output logic               move_up,
    output logic               move_down,
    output logic               fire_pulse
);
    logic [NUM_BTN-1:0] st;
    logic [3:0]         move_q;
    logic               fire_q, fire_d;
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .CLOCK_50(CLOCK_50),
            .reset   (reset),
            .raw_n   (gpio_n[i]),
            .stable  (st[i])
        );
    end
    assign btn_state = st;
`ifdef FIRE_AUTOREPEAT_EN
    localparam int TMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
    fire_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    // IDLE only persists while fire is released, so fire seen high in IDLE is the press edge
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        fire_d  = 1'b0;
        if (!st[BTN_FIRE]) begin
            state_d = FIRE_IDLE;
            timer_d = '0;
        end else if (state_q == FIRE_IDLE) begin
            state_d = FIRE_HOLD;
            timer_d = '0;
            fire_d  = 1'b1;
        end else if (timer_q == (state_q == FIRE_HOLD ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_PERIOD - 1))) begin
            state_d = FIRE_REPEAT;
            timer_d = '0;
            fire_d  = 1'b1;
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= FIRE_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end
`else
    logic fire_prev_q;
    assign fire_d = st[BTN_FIRE] & ~fire_prev_q;
    always_ff @(posedge CLOCK_50) fire_prev_q <= reset ? 1'b0 : st[BTN_FIRE];
`endif
    // opposing directions held together cancel on their own axis only
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            move_q <= '0;
            fire_q <= 1'b0;
        end else begin
            move_q <= {st[BTN_DOWN] & ~st[BTN_UP], st[BTN_UP] & ~st[BTN_DOWN],
                       st[BTN_RIGHT] & ~st[BTN_LEFT], st[BTN_LEFT] & ~st[BTN_RIGHT]};
            fire_q <= fire_d;
        end
    end
    assign move_left  = move_q[BTN_LEFT];
    assign move_right = move_q[BTN_RIGHT];
    assign move_up    = move_q[BTN_UP];
    assign move_down  = move_q[BTN_DOWN];
    assign fire_pulse = fire_q;
endmodule

// File: tb/tb_controle_gpio.sv
// tb_controle_gpio: directed vectors for controle_gpio with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_controle_gpio;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] gpio_n;
    logic [4:0] btn_state;
    logic       move_left, move_right, move_up, move_down, fire_pulse;
    int         vectors = 0;
    int         miscompares = 0;

    controle_gpio #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .gpio_n    (gpio_n),
        .btn_state (btn_state),
        .move_left (move_left),
        .move_right(move_right),
        .move_up   (move_up),
        .move_down (move_down),
        .fire_pulse(fire_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] outs();
        return {btn_state, move_left, move_right, move_up, move_down, fire_pulse};
    endfunction

    int pulses[$];
    int bounce_rise;
`ifdef FIRE_AUTOREPEAT_EN
    localparam int EXP_PULSES = 11;
    localparam int EXP_SECOND = 17;
`else
    localparam int EXP_PULSES = 1;
    localparam int EXP_SECOND = 0;
`endif

    initial begin
        reset  = 1'b1;
        gpio_n = 5'b11111;
        step(3);
        check("reset_outs", 32'(outs()), 0);
        reset = 1'b0;
        step(3);
        check("post_reset_outs", 32'(outs()), 0);

        gpio_n[0] = 1'b0;
        step(5);
        check("left_lat5", 32'(btn_state[0]), 0);
        step(1);
        check("left_lat6", 32'(btn_state[0]), 1);
        check("move_left_lag", 32'(move_left), 0);
        step(1);
        check("move_left_on", 32'(move_left), 1);
        gpio_n[0] = 1'b1;
        step(5);
        check("left_rel5", 32'(btn_state[0]), 1);
        step(1);
        check("left_rel6", 32'(btn_state[0]), 0);
        step(1);
        check("move_left_off", 32'(move_left), 0);

        gpio_n[1] = 1'b0;
        step(3);
        gpio_n[1] = 1'b1;
        bounce_rise = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (btn_state[1]) bounce_rise++;
        end
        check("bounce_no_rise", 32'(bounce_rise), 0);
        gpio_n[1] = 1'b0;
        step(5);
        check("right_after_bounce5", 32'(btn_state[1]), 0);
        step(1);
        check("right_after_bounce6", 32'(btn_state[1]), 1);
        step(2);
        check("move_right_on", 32'(move_right), 1);

        gpio_n[0] = 1'b0;
        step(8);
        check("lr_state", 32'(btn_state), 32'b00011);
        check("lr_moves", 32'({move_left, move_right}), 0);
        gpio_n[1] = 1'b1;
        step(8);
        check("lr_release_right", 32'({move_left, move_right}), 32'b10);
        gpio_n[0] = 1'b1;
        gpio_n[2] = 1'b0;
        gpio_n[3] = 1'b0;
        step(8);
        check("ud_state", 32'(btn_state), 32'b01100);
        check("ud_moves", 32'({move_up, move_down}), 0);
        gpio_n[1] = 1'b0;
        gpio_n[3] = 1'b1;
        step(8);
        check("diag_moves", 32'({move_left, move_right, move_up, move_down}), 32'b0110);
        gpio_n = 5'b11111;
        step(10);
        check("all_released", 32'(outs()), 0);

        gpio_n[4] = 1'b0;
        for (int i = 1; i <= 55; i++) begin
            if (i == 41) gpio_n[4] = 1'b1;
            step(1);
            if (fire_pulse) pulses.push_back(i);
        end
        check("fire_count", 32'(pulses.size()), 32'(EXP_PULSES));
        check("fire_first", pulses.size() > 0 ? 32'(pulses[0]) : 32'hFFFF, 7);
        check("fire_second", pulses.size() > 1 ? 32'(pulses[1]) : 0, 32'(EXP_SECOND));
        check("fire_last", 32'(pulses[$]), 32'(EXP_PULSES == 1 ? 7 : 44));

        gpio_n[4] = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        check("reset_mid_debounce", 32'(outs()), 0);
        step(1);
        reset = 1'b0;
        step(6);
        check("redebounce6", 32'(fire_pulse), 0);
        step(1);
        check("redebounce7", 32'(fire_pulse), 1);
        step(1);
        check("redebounce8", 32'(fire_pulse), 0);
        step(14);
        reset = 1'b1;
        step(1);
        check("reset_mid_repeat", 32'(outs()), 0);
        step(1);
        reset = 1'b0;
        step(6);
        check("rerepeat6", 32'(fire_pulse), 0);
        step(1);
        check("rerepeat7", 32'(fire_pulse), 1);
        gpio_n = 5'b11111;
        step(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
